// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: a shared prescaler tick drives per-channel
// phase counters that produce OFF / ON / BLINK / PWM patterns on registered LED outputs.
module led_pattern_gen #(
    parameter int NCH     = 8,
    parameter int CLK_HZ  = 100000000,
    parameter int TICK_HZ = 1000,
    parameter int PER_W   = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 en,
    input  logic                 sync_restart,
    input  logic [2*NCH-1:0]     mode,
    input  logic [PER_W*NCH-1:0] period,
    input  logic [PER_W*NCH-1:0] duty,
    output logic [NCH-1:0]       led,
    output logic                 tick,
    output logic [NCH-1:0]       wrap
);

    localparam int PRESC   = CLK_HZ / TICK_HZ;
    localparam int PRESC_W = (PRESC >= 2) ? $clog2(PRESC) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESC - 1);

    if (PRESC < 2) begin : g_presc_check
        $error("led_pattern_gen: CLK_HZ/TICK_HZ must be at least 2");
    end

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_e;

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               tick_q, tick_d;
    logic [PER_W-1:0]   ph_q [NCH];
    logic [PER_W-1:0]   ph_d [NCH];
    mode_e              mode_q [NCH];
    mode_e              mode_d [NCH];
    logic [NCH-1:0]     blink_q, blink_d;
    logic [NCH-1:0]     led_q, led_d;
    logic [NCH-1:0]     wrap_q, wrap_d;
    logic               tick_ev;

    always_comb begin
        tick_ev = en && (presc_q == PRESC_MAX) && !sync_restart;
        tick_d  = tick_ev;

        presc_d = presc_q;
        if (sync_restart) begin
            presc_d = '0;
        end else if (en) begin
            presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PRESC_W'(1);
        end

        blink_d = blink_q;
        led_d   = '0;
        wrap_d  = '0;
        for (int unsigned i = 0; i < NCH; i++) begin : g_ch
            mode_e            mode_in;
            logic [PER_W-1:0] per;
            logic [PER_W-1:0] p_last;

            mode_in = mode_e'(mode[2*i +: 2]);
            per     = period[PER_W*i +: PER_W];
            p_last  = (per == '0) ? '0 : per - PER_W'(1);

            ph_d[i]   = ph_q[i];
            mode_d[i] = mode_in;

            // Mode change and sync_restart both restart the channel and suppress wrap;
            // ">=" makes a period shrink below the current phase wrap on the next tick.
            if ((mode_in != mode_q[i]) || sync_restart) begin
                ph_d[i]    = '0;
                blink_d[i] = 1'b0;
            end else if (tick_ev) begin
                if (ph_q[i] >= p_last) begin
                    ph_d[i]    = '0;
                    wrap_d[i]  = 1'b1;
                    blink_d[i] = ~blink_q[i];
                end else begin
                    ph_d[i] = ph_q[i] + PER_W'(1);
                end
            end

            case (mode_in)
                MODE_OFF:   led_d[i] = 1'b0;
                MODE_ON:    led_d[i] = 1'b1;
                MODE_BLINK: led_d[i] = blink_d[i];
                MODE_PWM:   led_d[i] = (ph_d[i] < duty[PER_W*i +: PER_W]);
                default:    led_d[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            blink_q <= '0;
            led_q   <= '0;
            wrap_q  <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                ph_q[i]   <= '0;
                mode_q[i] <= MODE_OFF;
            end
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            blink_q <= blink_d;
            led_q   <= led_d;
            wrap_q  <= wrap_d;
            for (int unsigned i = 0; i < NCH; i++) begin
                ph_q[i]   <= ph_d[i];
                mode_q[i] <= mode_d[i];
            end
        end
    end

    assign led  = led_q;
    assign tick = tick_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed scoreboard bench for led_pattern_gen with PRESC=10, two channels, 8-bit periods.
module tb_led_pattern_gen;

    localparam int NCH   = 2;
    localparam int PER_W = 8;

    localparam logic [4:0] M_ALL   = 5'b11111;
    localparam logic [4:0] M_LED1  = 5'b10000;
    localparam logic [4:0] M_LED0  = 5'b01000;
    localparam logic [4:0] M_TICK  = 5'b00100;
    localparam logic [4:0] M_WRAP0 = 5'b00001;

    logic                 sys_clk = 1'b0;
    logic                 sys_rst = 1'b0;
    logic                 en = 1'b1;
    logic                 sync_restart = 1'b0;
    logic [2*NCH-1:0]     mode;
    logic [PER_W*NCH-1:0] period;
    logic [PER_W*NCH-1:0] duty;
    logic [NCH-1:0]       led;
    logic                 tick;
    logic [NCH-1:0]       wrap;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [4:0] mask;
        logic [4:0] val;
    } exp_t;

    exp_t sb[$];

    always #5 sys_clk = ~sys_clk;

    led_pattern_gen #(
        .NCH(NCH),
        .CLK_HZ(1000),
        .TICK_HZ(100),
        .PER_W(PER_W)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .en(en),
        .sync_restart(sync_restart),
        .mode(mode),
        .period(period),
        .duty(duty),
        .led(led),
        .tick(tick),
        .wrap(wrap)
    );

    // Bit order of packed expectations: {led1, led0, tick, wrap1, wrap0}
    function automatic logic [4:0] pk(input bit l1, input bit l0, input bit t,
                                      input bit w1, input bit w0);
        return {l1, l0, t, w1, w0};
    endfunction

    task automatic compare_head();
        exp_t       e;
        logic [4:0] o;
        e = sb.pop_front();
        o = {led[1], led[0], tick, wrap[1], wrap[0]};
        checks++;
        assert ((o & e.mask) === (e.val & e.mask)) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b (mask %b)",
                   e.tag, o & e.mask, e.val & e.mask, e.mask);
        end
    endtask

    task automatic cyc(input string tag, input logic [4:0] mask, input logic [4:0] val);
        sb.push_back('{tag, mask, val});
        @(posedge sys_clk);
        #1;
        compare_head();
    endtask

    task automatic check_now(input string tag, input logic [4:0] mask, input logic [4:0] val);
        sb.push_back('{tag, mask, val});
        compare_head();
    endtask

    // Sequence after reset release: ch0 BLINK period 5, ch1 PWM period 4 duty 1
    task automatic run_from_reset(input string tag, input int n);
        for (int k = 1; k <= n; k++) begin
            cyc($sformatf("%s k=%0d", tag, k), M_ALL,
                pk(((k / 10) % 4) == 0, ((k / 50) % 2) == 1, (k % 10) == 0,
                   (k % 40) == 0, (k % 50) == 0));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mode   = {2'd3, 2'd2};
        period = {8'd4, 8'd5};
        duty   = {8'd1, 8'd0};

        // Async assertion before any clock edge
        #1 sys_rst = 1'b1;
        #1 check_now("reset async", M_ALL, 5'b00000);
        repeat (3) cyc("reset hold", M_ALL, 5'b00000);
        sys_rst = 1'b0;

        run_from_reset("sc1", 200);

        duty[15:8] = 8'd0;
        for (int j = 1; j <= 40; j++) cyc($sformatf("sc2 duty0 j=%0d", j), M_LED1, 5'b00000);
        duty[15:8] = 8'd7;
        for (int j = 1; j <= 40; j++) cyc($sformatf("sc2 duty7 j=%0d", j), M_LED1, M_LED1);

        sync_restart = 1'b1;
        period[7:0]  = 8'd10;
        cyc("sc3 sync", M_LED0 | M_TICK | M_WRAP0, 5'b00000);
        sync_restart = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            cyc($sformatf("sc3 k=%0d", k), M_LED0 | M_TICK | M_WRAP0,
                pk(1'b0, 1'b0, (k % 10) == 0, 1'b0, 1'b0));
        end
        period[7:0] = 8'd3;
        for (int k = 71; k <= 150; k++) begin
            cyc($sformatf("sc3 shrink k=%0d", k), M_LED0 | M_TICK | M_WRAP0,
                pk(1'b0, (k >= 80 && k < 110) || k >= 140, (k % 10) == 0,
                   1'b0, k == 80 || k == 110 || k == 140));
        end

        mode[1:0]   = 2'd1;
        period[7:0] = 8'd5;
        for (int k = 151; k <= 153; k++) cyc($sformatf("sc4 on k=%0d", k), M_LED0 | M_WRAP0, M_LED0);
        mode[1:0] = 2'd2;
        for (int k = 154; k <= 249; k++) begin
            cyc($sformatf("sc4 blink k=%0d", k), M_LED0 | M_TICK | M_WRAP0,
                pk(1'b0, k >= 200, (k % 10) == 0, 1'b0, k == 200));
        end

        // Edge 250 is both a tick event and a ch0 wrap point
        sync_restart = 1'b1;
        cyc("sc5 sync on tick", M_LED0 | M_TICK | M_WRAP0, 5'b00000);
        sync_restart = 1'b0;
        for (int j = 1; j <= 60; j++) begin
            cyc($sformatf("sc5 j=%0d", j), M_LED0 | M_TICK | M_WRAP0,
                pk(1'b0, j >= 50, (j % 10) == 0, 1'b0, j == 50));
        end

        #3 sys_rst = 1'b1;
        #1 check_now("sc6 async", M_ALL, 5'b00000);
        duty[15:8] = 8'd1;
        repeat (3) cyc("sc6 hold", M_ALL, 5'b00000);
        sys_rst = 1'b0;
        run_from_reset("sc6", 120);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
